// File: rtl/video_timing_generator.sv
// video_timing_generator: enable-paced raster counters with IDLE/RUN/DRAIN frame control and registered syncs
module video_timing_generator #(
  parameter int H_ACTIVE = 320,
  parameter int H_FP     = 20,
  parameter int H_SYNC   = 30,
  parameter int H_BP     = 38,
  parameter int V_ACTIVE = 240,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 15,
  parameter int SYNC_POL = 0
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iEnClk,
  input  logic       iRun,
  output logic       oHsync,
  output logic       oVsync,
  output logic       oDe,
  output logic [9:0] oHcnt,
  output logic [9:0] oVcnt,
  output logic       oFrameStart,
  output logic       oBusy
);
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] H_SS   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SE   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_SS   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SE   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic       POL    = 1'(SYNC_POL);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t     state, state_n;
  logic [9:0] h_n, v_n;
  logic       fs_n, busy_n, de_n, hs_n, vs_n, h_end, last;
  always_comb begin
    state_n = state;
    h_n     = '0;
    v_n     = '0;
    fs_n    = 1'b0;
    h_end   = oHcnt == H_LAST;
    last    = h_end && oVcnt == V_LAST;
    if (state == IDLE) begin
      state_n = iRun ? RUN : IDLE;
      fs_n    = iRun;
    end else if (last) begin
      state_n = iRun ? RUN : IDLE;
      fs_n    = iRun;
    end else begin
      state_n = iRun ? RUN : DRAIN;
      h_n     = h_end ? 10'd0 : oHcnt + 10'd1;
      v_n     = h_end ? oVcnt + 10'd1 : oVcnt;
    end
    // outputs derive from the next counters so they align with oHcnt/oVcnt
    busy_n = state_n != IDLE;
    de_n   = busy_n && h_n < H_ACT && v_n < V_ACT;
    hs_n   = busy_n && h_n >= H_SS && h_n < H_SE;
    vs_n   = busy_n && v_n >= V_SS && v_n < V_SE;
  end
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state       <= IDLE;
      oHcnt       <= '0;
      oVcnt       <= '0;
      oDe         <= 1'b0;
      oFrameStart <= 1'b0;
      oBusy       <= 1'b0;
      oHsync      <= !POL;
      oVsync      <= !POL;
    end else begin
      oFrameStart <= iEnClk && fs_n;
      if (iEnClk) begin
        state  <= state_n;
        oHcnt  <= h_n;
        oVcnt  <= v_n;
        oDe    <= de_n;
        oBusy  <= busy_n;
        oHsync <= hs_n ~^ POL;
        oVsync <= vs_n ~^ POL;
      end
    end
  end
endmodule

// File: tb/tb_video_timing_generator.sv
// tb_video_timing_generator: directed steps against a linear-pixel-index reference model via a scoreboard queue
module tb_video_timing_generator;
  localparam int HA = 8, HFP = 2, HS = 3, HBP = 2;
  localparam int VA = 6, VFP = 1, VS = 2, VBP = 1;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam logic POL = 1'b0;
  logic       iClk = 1'b0, iRst = 1'b1, iEnClk = 1'b0, iRun = 1'b0;
  logic       oHsync, oVsync, oDe, oFrameStart, oBusy;
  logic [9:0] oHcnt, oVcnt;
  logic [24:0] q[$];
  int checks = 0, errors = 0, fs_seen = 0;
  int m_st = 0, m_h = 0, m_v = 0;
  logic m_fs = 1'b0;
  video_timing_generator #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(0)
  ) dut (
    .iClk(iClk), .iRst(iRst), .iEnClk(iEnClk), .iRun(iRun),
    .oHsync(oHsync), .oVsync(oVsync), .oDe(oDe), .oHcnt(oHcnt), .oVcnt(oVcnt),
    .oFrameStart(oFrameStart), .oBusy(oBusy)
  );
  always #5 iClk = ~iClk;
  function automatic logic [24:0] model_out();
    logic b, de, hs, vs;
    b  = m_st != 0;
    de = b && m_h < HA && m_v < VA;
    hs = b && m_h >= HA + HFP && m_h < HA + HFP + HS;
    vs = b && m_v >= VA + VFP && m_v < VA + VFP + VS;
    return {b, m_fs, de, hs ? POL : !POL, vs ? POL : !POL, 10'(m_h), 10'(m_v)};
  endfunction
  task automatic model(input logic en, input logic run, input logic rst);
    int p;
    if (rst) begin
      m_st = 0; m_h = 0; m_v = 0; m_fs = 1'b0;
    end else begin
      m_fs = 1'b0;
      if (en && m_st == 0) begin
        if (run) begin m_st = 1; m_fs = 1'b1; end
      end else if (en) begin
        p = m_v * HT + m_h + 1;
        if (p == HT * VT) begin
          m_st = run ? 1 : 0; m_fs = run; m_h = 0; m_v = 0;
        end else begin
          m_st = run ? 1 : 2; m_h = p % HT; m_v = p / HT;
        end
      end
    end
  endtask
  task automatic step(input logic en, input logic run, input logic rst, input string tag);
    logic [24:0] e, o;
    iEnClk = en; iRun = run; iRst = rst;
    model(en, run, rst);
    q.push_back(model_out());
    @(posedge iClk); #1;
    e = q.pop_front();
    o = {oBusy, oFrameStart, oDe, oHsync, oVsync, oHcnt, oVcnt};
    if (oFrameStart) fs_seen++;
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, o, e);
    end
  endtask
  task automatic expect_eq(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask
  task automatic run_until(input logic run, input int h, input int v, input string tag);
    bit hit = 0;
    for (int i = 0; i < 4 * HT * VT && !hit; i++) begin
      step(1'b1, run, 1'b0, tag);
      hit = m_h == h && m_v == v;
    end
    expect_eq({tag, "_reached"}, int'(hit), 1);
  endtask
  initial begin
    int n, de_cnt, fs0, lh, lv;
    bit hit;
    step(1'b0, 1'b1, 1'b1, "reset0");
    step(1'b1, 1'b1, 1'b1, "reset1");
    for (int i = 0; i < 6; i++) step(i[0], 1'b0, 1'b0, "idle_hold");
    // two frames with gaps of three idle clocks between enables
    fs0 = fs_seen;
    step(1'b1, 1'b1, 1'b0, "first_enable");
    expect_eq("first_fs", int'(oFrameStart), 1);
    step(1'b0, 1'b1, 1'b0, "fs_clears");
    for (int i = 1; i < 2 * HT * VT; i++) begin
      for (int g = 0; g < 3; g++) step(1'b0, 1'b1, 1'b0, "gap");
      step(1'b1, 1'b1, 1'b0, "gapped_run");
    end
    expect_eq("fs_in_two_frames", fs_seen - fs0, 2);
    // continuous enable: frame period and active pixel count
    hit = 0;
    for (int i = 0; i < 2 * HT * VT && !hit; i++) begin
      step(1'b1, 1'b1, 1'b0, "seek_fs");
      hit = oFrameStart;
    end
    expect_eq("seek_fs_found", int'(hit), 1);
    n = 0; de_cnt = int'(oDe); hit = 0;
    for (int i = 0; i < 2 * HT * VT && !hit; i++) begin
      step(1'b1, 1'b1, 1'b0, "cont_frame");
      n++;
      hit = oFrameStart;
      if (!hit) de_cnt += int'(oDe);
    end
    expect_eq("frame_period", n, HT * VT);
    expect_eq("de_count", de_cnt, HA * VA);
    // drop run mid-frame: drain to end then idle without a new frame
    run_until(1'b1, 0, 4, "to_v4");
    step(1'b1, 1'b0, 1'b0, "enter_drain");
    expect_eq("drain_busy", int'(oBusy), 1);
    fs0 = fs_seen; hit = 0; lh = 0; lv = 0;
    for (int i = 0; i < 2 * HT * VT && !hit; i++) begin
      lh = int'(oHcnt); lv = int'(oVcnt);
      step(1'b1, 1'b0, 1'b0, "draining");
      hit = !oBusy;
    end
    expect_eq("drain_idle", int'(hit), 1);
    expect_eq("drain_last_h", lh, HT - 1);
    expect_eq("drain_last_v", lv, VT - 1);
    expect_eq("drain_no_fs", fs_seen - fs0, 0);
    // drop and restore run: frame continues and the next one starts
    step(1'b1, 1'b1, 1'b0, "restart");
    run_until(1'b1, 0, 3, "to_v3");
    run_until(1'b0, 0, 6, "drain_to_v6");
    expect_eq("mid_drain_busy", int'(oBusy), 1);
    fs0 = fs_seen;
    run_until(1'b1, 0, 0, "resume_to_wrap");
    expect_eq("resume_fs", fs_seen - fs0, 1);
    expect_eq("resume_busy", int'(oBusy), 1);
    // reset mid-frame coinciding with an enable
    run_until(1'b1, 5, 4, "to_5_4");
    step(1'b1, 1'b1, 1'b1, "mid_reset");
    expect_eq("mid_reset_vec", int'({oBusy, oFrameStart, oDe, oHsync, oVsync, oHcnt, oVcnt}), int'({4'b0001, 1'b1, 20'd0}));
    step(1'b0, 1'b1, 1'b0, "post_reset_wait");
    step(1'b1, 1'b1, 1'b0, "post_reset_start");
    expect_eq("post_reset_fs", int'(oFrameStart), 1);
    expect_eq("scoreboard_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
